gray_code_decoder: RTL and testbench

//   Receive end of the gray-code counter link: converts a streamed WIDTH-bit gray code back to binary

---
 rtl/gray_code_decoder_pkg.sv | 42 ++++
 rtl/gray_to_binary_stage.sv | 45 ++++
 rtl/gray_code_decoder.sv | 113 +++++++++++
 tb/tb_gray_code_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_code_decoder_pkg.sv
// Shared definitions for the gray-code link: checker states, pipeline slicing
// helpers and gray<->binary reference conversions.
package gray_code_decoder_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_SEEK  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } chk_state_e;

    // Bits resolved per pipeline stage, rounded up so every bit is covered.
    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int stage_hi(input int width, input int stages, input int k);
        return width - 1 - k * chunk_size(width, stages);
    endfunction

    // Trailing stages of a non-even split may own fewer bits (or none).
    function automatic int stage_lo(input int width, input int stages, input int k);
        int lo;
        lo = width - (k + 1) * chunk_size(width, stages);
        return (lo < 0) ? 0 : lo;
    endfunction

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary_stage.sv
// One slice of the pipelined prefix-XOR: bits above HI arrive already binary,
// bits HI..LO are resolved here, bits below LO pass through still gray-coded.
module gray_to_binary_stage #(
    parameter int WIDTH = 32,
    parameter int LO    = 0,
    parameter int HI    = WIDTH - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // The MSB of a gray code equals the binary MSB, so it never needs rewriting.
    always_comb begin
        data_d = data_i;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i >= LO && i <= HI) begin
                data_d[i] = data_d[i+1] ^ data_i[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/gray_code_decoder.sv
// Receive side of the gray-code counter link: pipelined gray->binary decode
// followed by a +1 step checker with lock indication and saturating error count.
module gray_code_decoder
    import gray_code_decoder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = 4,
    parameter int ERR_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_error,
    output logic             locked,
    output logic [ERR_W-1:0] error_count,
    output logic [1:0]       dbg_state
);

    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    // Handshake: gray_valid qualifies gray_in for one cycle, no backpressure;
    // bin_valid qualifies bin_out exactly STAGES cycles later, bubbles preserved.
    logic [WIDTH-1:0] pipe_data  [0:STAGES];
    logic             pipe_valid [0:STAGES];

    assign pipe_data[0]  = gray_in;
    assign pipe_valid[0] = gray_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_to_binary_stage #(
            .WIDTH (WIDTH),
            .LO    (stage_lo(WIDTH, STAGES, k)),
            .HI    (stage_hi(WIDTH, STAGES, k))
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .data_i  (pipe_data[k]),
            .valid_i (pipe_valid[k]),
            .data_o  (pipe_data[k+1]),
            .valid_o (pipe_valid[k+1])
        );
    end

    assign bin_out   = pipe_data[STAGES];
    assign bin_valid = pipe_valid[STAGES];

    chk_state_e       state_q;
    logic [WIDTH-1:0] prev_q;
    logic             step_error_q;
    logic             locked_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             good_step;

    // Natural WIDTH-bit wrap makes all-ones -> zero a legal step.
    assign good_step = (bin_out == prev_q + WIDTH'(1));

    // clear outranks a coincident sample: that sample is dropped, not used as reference.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SEEK;
            prev_q       <= '0;
            step_error_q <= 1'b0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            step_error_q <= 1'b0;
            if (clear) begin
                state_q   <= ST_SEEK;
                locked_q  <= 1'b0;
                err_cnt_q <= '0;
            end else if (bin_valid) begin
                prev_q <= bin_out;
                case (state_q)
                    ST_SEEK: begin
                        state_q  <= ST_TRACK;
                        locked_q <= 1'b1;
                    end
                    ST_TRACK: begin
                        if (!good_step) begin
                            state_q      <= ST_FAULT;
                            locked_q     <= 1'b0;
                            step_error_q <= 1'b1;
                            if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + ERR_W'(1);
                        end
                    end
                    ST_FAULT: begin
                        if (good_step) begin
                            state_q  <= ST_TRACK;
                            locked_q <= 1'b1;
                        end else begin
                            step_error_q <= 1'b1;
                            if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + ERR_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_SEEK;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step_error  = step_error_q;
    assign locked      = locked_q;
    assign error_count = err_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gray_code_decoder.sv
// Directed bench for gray_code_decoder: scoreboarded decode data/latency plus
// checker state, lock, step_error pulse count and error counter checks.
module tb_gray_code_decoder;
    import gray_code_decoder_pkg::*;

    localparam int W  = 16;
    localparam int S  = 3;
    localparam int EW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  gray_in;
    logic          gray_valid;
    logic          clear;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          step_error;
    logic          locked;
    logic [EW-1:0] error_count;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int se_cnt   = 0;
    int se_base  = 0;

    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];

    gray_code_decoder #(.WIDTH(W), .STAGES(S), .ERR_W(EW)) dut (
        .clock       (clock),
        .reset       (reset),
        .gray_in     (gray_in),
        .gray_valid  (gray_valid),
        .clear       (clear),
        .bin_out     (bin_out),
        .bin_valid   (bin_valid),
        .step_error  (step_error),
        .locked      (locked),
        .error_count (error_count),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: pops one expected sample per bin_valid, checks value and arrival cycle
    task automatic monitor();
        logic [W-1:0] e;
        int           t;
        if (step_error === 1'b1) se_cnt++;
        if (bin_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bin_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("bin_out", 32'(bin_out), 32'(e));
                check("latency", 32'(cyc), 32'(t));
            end
        end
    endtask

    // driver: one clock cycle with the given binary value sent gray-coded
    task automatic step(input logic [W-1:0] b, input logic v, input logic c);
        gray_in    = W'(bin2gray(64'(b)));
        gray_valid = v;
        clear      = c;
        if (v) begin
            exp_q.push_back(b);
            exp_t_q.push_back(cyc + S);
        end
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < S + 4 && exp_q.size() != 0; i++) step('0, 1'b0, 1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    task automatic check_chk(input string tag, input logic [1:0] st, input logic lk,
                             input int cnt, input int pulses);
        check({tag, "_state"},  32'(dbg_state),   32'(st));
        check({tag, "_locked"}, 32'(locked),      32'(lk));
        check({tag, "_count"},  32'(error_count), 32'(cnt));
        check({tag, "_pulses"}, 32'(se_cnt - se_base), 32'(pulses));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bin_out"},    32'(bin_out),     32'd0);
        check({tag, "_bin_valid"},  32'(bin_valid),   32'd0);
        check({tag, "_step_error"}, 32'(step_error),  32'd0);
        check({tag, "_locked"},     32'(locked),      32'd0);
        check({tag, "_count"},      32'(error_count), 32'd0);
        check({tag, "_state"},      32'(dbg_state),   32'(ST_SEEK));
    endtask

    initial begin
        logic [W-1:0] val;

        reset      = 1'b0;
        gray_in    = '0;
        gray_valid = 1'b0;
        clear      = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // continuous counting stream
        se_base = se_cnt;
        for (int i = 0; i < 2000; i++) step(W'(i), 1'b1, 1'b0);
        drain();
        check_chk("count_run", ST_TRACK, 1'b1, 0, 0);

        // wrap from all-ones to zero is a legal step
        step('0, 1'b0, 1'b1);
        check_chk("after_clear", ST_SEEK, 1'b0, 0, 0);
        se_base = se_cnt;
        for (int i = 0; i < 12; i++) step(W'(65530 + i), 1'b1, 1'b0);
        drain();
        check_chk("wrap", ST_TRACK, 1'b1, 0, 0);

        // single skip then resync
        step('0, 1'b0, 1'b1);
        se_base = se_cnt;
        step(W'(10), 1'b1, 1'b0);
        step(W'(11), 1'b1, 1'b0);
        step(W'(13), 1'b1, 1'b0);
        drain();
        check_chk("skip", ST_FAULT, 1'b0, 1, 1);
        step(W'(14), 1'b1, 1'b0);
        drain();
        check_chk("resync", ST_TRACK, 1'b1, 1, 1);

        // bubbles keep their slot
        step('0, 1'b0, 1'b1);
        se_base = se_cnt;
        val = '0;
        for (int i = 0; i <= 100; i++) begin
            step(val, (i % 3) == 0, 1'b0);
            if ((i % 3) == 0) val++;
        end
        drain();
        check_chk("bubbles", ST_TRACK, 1'b1, 0, 0);

        // repeated value, then clear coinciding with a valid sample
        step('0, 1'b0, 1'b1);
        se_base = se_cnt;
        for (int i = 0; i < 3; i++) step(W'(5), 1'b1, 1'b0);
        drain();
        check_chk("repeat", ST_FAULT, 1'b0, 2, 2);
        se_base = se_cnt;
        step(W'(9), 1'b1, 1'b0);
        idle(S - 1);
        step('0, 1'b0, 1'b1);
        check_chk("clear_on_valid", ST_SEEK, 1'b0, 0, 0);
        step(W'(20), 1'b1, 1'b0);
        drain();
        check_chk("new_ref", ST_TRACK, 1'b1, 0, 0);

        // saturating counter: six bad steps in a row
        se_base = se_cnt;
        step(W'(20), 1'b1, 1'b0);
        for (int i = 3; i <= 7; i++) step(W'(i * 10), 1'b1, 1'b0);
        drain();
        check_chk("saturate", ST_FAULT, 1'b0, 3, 6);

        // asynchronous reset mid-stream
        step(W'(100), 1'b1, 1'b0);
        step(W'(101), 1'b1, 1'b0);
        step(W'(102), 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        exp_t_q.delete();
        idle(2);
        check_all_zero("held_reset");
        reset = 1'b1;
        se_base = se_cnt;
        step(W'(500), 1'b1, 1'b0);
        step(W'(501), 1'b1, 1'b0);
        drain();
        check_chk("post_reset", ST_TRACK, 1'b1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
